// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-busy freeze
// and the HLT drain/halt sequence, with saturating stall/flush performance counters.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_EX,
  input  logic [3:0]  wr_reg_EX,
  input  logic [3:0]  rs_ID,
  input  logic [3:0]  rt_ID,
  input  logic        rs_used_ID,
  input  logic        rt_used_ID,
  input  logic        hlt_ID,
  input  logic        br_taken_MEM,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        pc_sel_alt,
  output logic        if_id_we,
  output logic        pipe_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DRAIN   = 2'b01,
    ST_HALTED  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  state_t      r_state;
  logic [1:0]  r_drain_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  state_t      w_next_state;
  logic [1:0]  w_next_drain;
  logic        w_stall_inc;
  logic        w_flush_inc;
  logic        w_lu;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) sat_inc = v;
    else               sat_inc = v + 16'd1;
  endfunction

  assign w_lu = ld_EX && (wr_reg_EX != 4'd0) &&
                ((rs_used_ID && (rs_ID == wr_reg_EX)) ||
                 (rt_used_ID && (rt_ID == wr_reg_EX)));

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Control outputs and next-state decode; mem_busy overrides everything afterwards.
  always_comb begin
    pc_we        = 1'b0;
    pc_sel_alt   = 1'b0;
    if_id_we     = 1'b0;
    pipe_en      = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    w_next_state = r_state;
    w_next_drain = r_drain_cnt;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    case (r_state)
      ST_RUN: begin
        pc_we    = 1'b1;
        if_id_we = 1'b1;
        pipe_en  = 1'b1;
        if (br_taken_MEM) begin
          pc_sel_alt   = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          w_flush_inc  = 1'b1;
        end else if (w_lu) begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
          w_stall_inc = 1'b1;
        end else if (hlt_ID) begin
          pc_we        = 1'b0;
          if_id_flush  = 1'b1;
          w_next_state = ST_DRAIN;
          w_next_drain = 2'd0;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        pipe_en  = 1'b1;
        if_id_we = 1'b1;
        if (br_taken_MEM) begin
          // An older branch still in flight cancels the HLT.
          pc_we        = 1'b1;
          pc_sel_alt   = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          w_flush_inc  = 1'b1;
          w_next_state = ST_RUN;
          w_next_drain = 2'd0;
        end else begin
          if_id_flush = 1'b1;
          if (r_drain_cnt == 2'd2) begin
            w_next_state = ST_HALTED;
          end else begin
            w_next_drain = r_drain_cnt + 2'd1;
          end
        end
      end
      default: begin
        halted = 1'b1;
      end
    endcase

    if (mem_busy) begin
      pc_we        = 1'b0;
      pc_sel_alt   = 1'b0;
      if_id_we     = 1'b0;
      pipe_en      = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      w_next_state = r_state;
      w_next_drain = r_drain_cnt;
      w_flush_inc  = 1'b0;
      w_stall_inc  = 1'b1;
    end else begin
      w_stall_inc  = w_stall_inc;
    end
  end

  // State, drain counter and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 2'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain;
      if (w_stall_inc) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush_inc) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expectations queued per step, popped and
// checked mid-cycle with immediate assertions.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_EX;
  logic [3:0]  wr_reg_EX, rs_ID, rt_ID;
  logic        rs_used_ID, rt_used_ID, hlt_ID, br_taken_MEM, mem_busy;
  logic        pc_we, pc_sel_alt, if_id_we, pipe_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  // {pc_we, pc_sel_alt, if_id_we, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush, halted}
  localparam logic [7:0] O_RUN   = 8'b1011_0000;
  localparam logic [7:0] O_BR    = 8'b1111_1110;
  localparam logic [7:0] O_LU    = 8'b0001_0100;
  localparam logic [7:0] O_HLT   = 8'b0011_1000;
  localparam logic [7:0] O_DRAIN = 8'b0011_1000;
  localparam logic [7:0] O_BUSY  = 8'b0000_0000;
  localparam logic [7:0] O_HALT  = 8'b0000_0001;

  typedef struct packed {
    logic [7:0]  o;
    logic [1:0]  st;
    logic [15:0] stl;
    logic [15:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ld_EX(ld_EX), .wr_reg_EX(wr_reg_EX),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_used_ID(rs_used_ID), .rt_used_ID(rt_used_ID),
    .hlt_ID(hlt_ID), .br_taken_MEM(br_taken_MEM), .mem_busy(mem_busy),
    .pc_we(pc_we), .pc_sel_alt(pc_sel_alt), .if_id_we(if_id_we), .pipe_en(pipe_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .halted(halted), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), check, advance.
  task automatic step(input string tag, input logic ld, input logic [3:0] wr,
                      input logic [3:0] rs, input logic [3:0] rt,
                      input logic rsu, input logic rtu, input logic hlt,
                      input logic br, input logic busy, input logic [7:0] eo,
                      input logic [1:0] est, input logic [15:0] estl,
                      input logic [15:0] efl);
    exp_t e;
    ld_EX = ld; wr_reg_EX = wr; rs_ID = rs; rt_ID = rt;
    rs_used_ID = rsu; rt_used_ID = rtu; hlt_ID = hlt;
    br_taken_MEM = br; mem_busy = busy;
    exp_q.push_back('{o: eo, st: est, stl: estl, fl: efl});
    #2;
    e = exp_q.pop_front();
    chk({tag, "/out"}, {8'd0, pc_we, pc_sel_alt, if_id_we, pipe_en,
                        if_id_flush, id_ex_flush, ex_mem_flush, halted}, {8'd0, e.o});
    chk({tag, "/state"}, {14'd0, state}, {14'd0, e.st});
    chk({tag, "/stall_cnt"}, stall_cnt, e.stl);
    chk({tag, "/flush_cnt"}, flush_cnt, e.fl);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic [7:0] eo, input logic [1:0] est,
                      input logic [15:0] estl, input logic [15:0] efl);
    step(tag, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eo, est, estl, efl);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "/state"}, {14'd0, state}, 16'd0);
    chk({tag, "/stall_cnt"}, stall_cnt, 16'd0);
    chk({tag, "/flush_cnt"}, flush_cnt, 16'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ld_EX = 1'b0; wr_reg_EX = 4'd0; rs_ID = 4'd0; rt_ID = 4'd0;
    rs_used_ID = 1'b0; rt_used_ID = 1'b0; hlt_ID = 1'b0;
    br_taken_MEM = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    idle("rst_hold0", O_RUN, 2'd0, 16'd0, 16'd0);
    idle("rst_hold1", O_RUN, 2'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    idle("idle0", O_RUN, 2'd0, 16'd0, 16'd0);

    // Load-use detection
    step("lu_wr0",   1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 2'd0, 16'd0, 16'd0);
    step("lu_rsu0",  1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 2'd0, 16'd0, 16'd0);
    step("lu_noload",1'b0, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, 2'd0, 16'd0, 16'd0);
    step("lu_rs",    1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,  2'd0, 16'd0, 16'd0);
    idle("after_lu", O_RUN, 2'd0, 16'd1, 16'd0);
    step("lu_rt",    1'b1, 4'd5, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,  2'd0, 16'd1, 16'd0);

    // Branch beats load-use and HLT
    step("br_all",   1'b1, 4'd5, 4'd0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_BR,  2'd0, 16'd2, 16'd0);
    idle("after_br", O_RUN, 2'd0, 16'd2, 16'd1);
    step("busy_br",  1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_BUSY, 2'd0, 16'd2, 16'd1);
    idle("after_busy", O_RUN, 2'd0, 16'd3, 16'd1);

    // HLT drain to halt
    step("hlt_T0",   1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_HLT, 2'd0, 16'd3, 16'd1);
    idle("hlt_T1", O_DRAIN, 2'd1, 16'd3, 16'd1);
    idle("hlt_T2", O_DRAIN, 2'd1, 16'd3, 16'd1);
    idle("hlt_T3", O_DRAIN, 2'd1, 16'd3, 16'd1);
    idle("hlt_T4", O_HALT,  2'd2, 16'd3, 16'd1);
    step("halt_ign", 1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, O_HALT, 2'd2, 16'd3, 16'd1);
    step("halt_busy",1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_HALT, 2'd2, 16'd3, 16'd1);
    idle("halt_post", O_HALT, 2'd2, 16'd4, 16'd1);

    async_reset_check("rst_halted");
    idle("rst_halted_hold", O_RUN, 2'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    idle("rst_halted_rel", O_RUN, 2'd0, 16'd0, 16'd0);

    // Branch cancels HLT during drain
    step("cxl_T0",   1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_HLT, 2'd0, 16'd0, 16'd0);
    idle("cxl_T1", O_DRAIN, 2'd1, 16'd0, 16'd0);
    step("cxl_T2",   1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_BR,  2'd1, 16'd0, 16'd0);
    idle("cxl_T3", O_RUN, 2'd0, 16'd0, 16'd1);

    // Memory busy stretches the drain
    step("dbusy_T0", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_HLT, 2'd0, 16'd0, 16'd1);
    step("dbusy_T1", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_BUSY, 2'd1, 16'd0, 16'd1);
    step("dbusy_T2", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_BUSY, 2'd1, 16'd1, 16'd1);
    idle("dbusy_T3", O_DRAIN, 2'd1, 16'd2, 16'd1);
    idle("dbusy_T4", O_DRAIN, 2'd1, 16'd2, 16'd1);
    idle("dbusy_T5", O_DRAIN, 2'd1, 16'd2, 16'd1);
    idle("dbusy_T6", O_HALT,  2'd2, 16'd2, 16'd1);

    // Reset mid-drain
    rst_n = 1'b0;
    idle("rst2_hold", O_RUN, 2'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    step("mdr_T0",   1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_HLT, 2'd0, 16'd0, 16'd0);
    idle("mdr_T1", O_DRAIN, 2'd1, 16'd0, 16'd0);
    rst_n = 1'b0;
    idle("mdr_hold", O_RUN, 2'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    idle("mdr_rel", O_RUN, 2'd0, 16'd0, 16'd0);

    // Stall counter saturation
    ld_EX = 1'b1; wr_reg_EX = 4'd7; rs_ID = 4'd7; rs_used_ID = 1'b1;
    for (int i = 0; i < 70000; i++) @(negedge clk);
    step("sat0", 1'b1, 4'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU, 2'd0, 16'hFFFF, 16'd0);
    step("sat1", 1'b1, 4'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU, 2'd0, 16'hFFFF, 16'd0);
    async_reset_check("rst_sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 ld_EX  in  1  instruction in EX is a load (dm_rd_en of ID/EX output).
REQ-004 wr_reg_EX  in  4  destination register of instruction in EX.
REQ-005 rs_ID, rt_ID  in  4 each  source registers of instruction in ID.
REQ-006 rs_used_ID, rt_used_ID  in  1 each  ID instruction actually reads rs / rt.
REQ-007 hlt_ID  in  1  instruction in ID is HLT.
REQ-008 br_taken_MEM  in  1  branch/JAL/JR resolved taken in MEM; redirect to alt_pc.
REQ-009 mem_busy  in  1  data/instruction memory not ready this cycle.
REQ-010 pc_we  out  1  PC register load enable.
REQ-011 pc_sel_alt  out  1  PC loads alt_pc instead of PC+1.
REQ-012 if_id_we  out  1  IF/ID register load enable.
REQ-013 pipe_en  out  1  load enable for ID/EX, EX/MEM, MEM/WB registers.
REQ-014 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load NOP (all zero) into that register at next edge.
REQ-015 halted  out  1  core halted.
REQ-016 state  out  2  FSM state: RUN=00, DRAIN=01, HALTED=10.
REQ-017 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-018 Outputs combinational from state and current inputs; state, drain counter and perf counters registered.
REQ-019 Load-use hazard lu = ld_EX & wr_reg_EX!=0 & ((rs_used_ID & rs_ID==wr_reg_EX) | (rt_used_ID & rt_ID==wr_reg_EX)).
REQ-020 Priority, highest first: mem_busy, br_taken_MEM, lu, hlt_ID.
REQ-021 mem_busy=1 (any state): pc_we=0, if_id_we=0, pipe_en=0, all flushes 0; state, drain counter frozen; stall_cnt +1.
REQ-022 RUN default: pc_we=1, if_id_we=1, pipe_en=1, pc_sel_alt=0, flushes 0, halted=0.
REQ-023 RUN, br_taken_MEM=1: pc_we=1, pc_sel_alt=1, if_id_flush=id_ex_flush=ex_mem_flush=1, pipe_en=1; flush_cnt +1; lu and hlt_ID ignored; stay RUN.
REQ-024 RUN, lu=1: pc_we=0, if_id_we=0, id_ex_flush=1, pipe_en=1; single bubble; stall_cnt +1; re-evaluated next cycle.
REQ-025 RUN, hlt_ID=1 (no higher event): pc_we=0, if_id_flush=1; next state DRAIN, drain counter cleared to 0.
REQ-026 DRAIN: pc_we=0, if_id_flush=1, pipe_en=1; drain counter +1 per non-busy cycle; at count 2 next state HALTED (HLT has passed WB).
REQ-027 DRAIN, br_taken_MEM=1 (older branch cancels HLT): REQ-023 outputs, next state RUN, counter cleared, flush_cnt +1.
REQ-028 HALTED: pc_we=0, if_id_we=0, pipe_en=0, flushes 0, halted=1; terminal until reset; br_taken_MEM, hlt_ID, lu ignored.
REQ-029 Counters saturate at 16'hFFFF, never wrap.
REQ-030 Illegal state 11 behaves as HALTED and holds.

Reset
REQ-031 rst_n=0 asynchronously forces state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0; outputs read RUN defaults while held.
REQ-032 Reset mid-DRAIN or in HALTED returns to RUN on first edge after release; no residual flush or stall.

Verification
REQ-033 ld_EX=1, wr_reg_EX=3, rs_ID=3, rs_used_ID=1 for one cycle -> that cycle pc_we=0, if_id_we=0, id_ex_flush=1; stall_cnt=1; next cycle (ld_EX=0) RUN defaults.
REQ-034 Same as REQ-033 with wr_reg_EX=0, or rs_used_ID=0 -> no stall, stall_cnt=0.
REQ-035 br_taken_MEM=1 together with lu=1 and hlt_ID=1 -> pc_sel_alt=1, three flushes 1, state stays RUN, flush_cnt=1.
REQ-036 hlt_ID=1 at T0 -> state DRAIN at T1-T3, HALTED at T4, halted=1, pc_we=0 from T0 onward.
REQ-037 hlt at T0, br_taken_MEM=1 at T2 -> state RUN at T3, pc_sel_alt=1 at T2; with mem_busy=1 during T1-T2, DRAIN extends 2 cycles, HALTED at T6.
REQ-038 Drive lu every cycle for 70000 cycles -> stall_cnt holds 16'hFFFF; assert rst_n=0 mid-run -> counters 0 immediately, state RUN.
